keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 187 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad matrix one column at a time,
// debounces both press and release of a single key, and presents the code
// {row[1:0], col[1:0]} while the key is held, plus a one-cycle key_valid
// strobe per accepted press. The first key found wins; other keys are ignored
// until it is released.
// Optional feature (macro KEYPAD_AUTOREPEAT_EN): while the key stays pressed,
// key_valid re-strobes every REPEAT_CYCLES cycles after the initial strobe.
module keypad_scanner #(
  parameter int SCAN_DWELL      = 4,   // >= 3 so the row synchronizer settles before sampling
  parameter int DEBOUNCE_CYCLES = 16,  // >= 2
  parameter int REPEAT_CYCLES   = 256  // only used with KEYPAD_AUTOREPEAT_EN
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] keypad,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE_P, PRESSED, DEBOUNCE_R} state_t;

  localparam int SCAN_DEB_MAX = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int MAX_TC = ((SCAN_DEB_MAX > REPEAT_CYCLES) ? SCAN_DEB_MAX : REPEAT_CYCLES) - 1;
`else
  localparam int MAX_TC = SCAN_DEB_MAX - 1;
`endif
  localparam int CNT_W = $clog2(MAX_TC) + 1;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // The PRESSED cycle that first sees the row high is the first of the
  // DEBOUNCE_CYCLES high reads, so DEBOUNCE_R itself needs one fewer.
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [3:0]       keypad_q, keypad_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;
  logic [3:0]       sync1_q, rows_s_q;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [CNT_W-1:0] rep_q, rep_d;
`endif

  logic row_high;

  // Lowest-index row currently pulled low (only meaningful when one is low).
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  assign row_high = rows_s_q[row_q];

  // Next-state logic: scan, debounce press, hold, debounce release.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    keypad_d    = keypad_q;
    key_down_d  = key_down_q;
    key_valid_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d       = rep_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (rows_s_q != 4'hF) begin
            row_d   = lowest_low_row(rows_s_q);
            deb_d   = '0;
            state_d = DEBOUNCE_P;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + ONE;
        end
      end
      DEBOUNCE_P: begin
        if (row_high) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
          deb_d   = '0;
        end else if (deb_q == PRESS_LAST) begin
          state_d     = PRESSED;
          deb_d       = '0;
          keypad_d    = {row_q, col_q};
          key_down_d  = 1'b1;
          key_valid_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_d       = '0;
`endif
        end else begin
          deb_d = deb_q + ONE;
        end
      end
      PRESSED: begin
        if (row_high) begin
          state_d = DEBOUNCE_R;
          deb_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_d   = '0;
        end else if (rep_q == REPEAT_LAST) begin
          key_valid_d = 1'b1;
          rep_d       = '0;
        end else begin
          rep_d = rep_q + ONE;
`endif
        end
      end
      DEBOUNCE_R: begin
        if (!row_high) begin
          state_d = PRESSED;
          deb_d   = '0;
        end else if (deb_q == RELEASE_LAST) begin
          state_d    = SCAN;
          col_d      = col_q + 2'd1;
          dwell_d    = '0;
          deb_d      = '0;
          keypad_d   = 4'b0000;
          key_down_d = 1'b0;
        end else begin
          deb_d = deb_q + ONE;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // State and output registers plus the 2-flop row synchronizer.
  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      dwell_q     <= '0;
      deb_q       <= '0;
      keypad_q    <= 4'b0000;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      sync1_q     <= 4'hF;
      rows_s_q    <= 4'hF;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      keypad_q    <= keypad_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      sync1_q     <= row_n;
      rows_s_q    <= sync1_q;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col_n     = ~(4'b0001 << col_q);
  assign keypad    = keypad_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner. A behavioural 4x4
// matrix pulls a row low only while its pressed key's column is driven low.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_keypad_scanner;

  logic        sys_clk   = 1'b0;
  logic        reset     = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  keypad;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys      = '0;   // bit r*4+c set = key (row r, col c) held
  logic        force_low = 1'b0;
  int          tests     = 0;
  int          fails     = 0;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int EXP_REPEATS = 3;
`else
  localparam int EXP_REPEATS = 0;
`endif

  keypad_scanner #(
    .SCAN_DWELL      (4),
    .DEBOUNCE_CYCLES (16),
    .REPEAT_CYCLES   (32)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .keypad    (keypad),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 sys_clk = ~sys_clk;

  // Keypad matrix: a row reads low when any held key on it sits on a driven column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
    if (force_low) row_n = 4'h0;
  end

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one = 4'b0001;
    return ~(one << c);
  endfunction

  function automatic logic [15:0] key_bit(input int r, input int c);
    logic [15:0] one = 16'h0001;
    return one << (r * 4 + c);
  endfunction

  task automatic wait_col(input int c);
    logic [3:0] prev;
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      prev = col_n;
      @(negedge sys_clk);
      if (col_n === col_pat(c) && prev !== col_pat(c)) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL wait_col%0d: column not reached in 64 cycles, col_n=%b", c, col_n);
    end
  endtask

  // Press keys as column c becomes active; strobe expected 20 cycles later
  // (4-cycle dwell to the sampling edge, then 16 debounce cycles).
  task automatic press_keys(input string name, input logic [15:0] mask, input int c,
                            input logic [3:0] code);
    int pulses   = 0;
    int pulse_at = -1;
    wait_col(c);
    keys = keys | mask;
    for (int n = 1; n <= 21; n++) begin
      @(negedge sys_clk);
      if (key_valid === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = n;
      end
      if (n == 19) begin
        tests++;
        if (key_down !== 1'b0) begin
          fails++;
          $display("FAIL %s early_down: key_down=%b want 0", name, key_down);
        end
      end
      if (n == 20) begin
        tests++;
        if (keypad !== code) begin
          fails++;
          $display("FAIL %s code: keypad=%b want %b", name, keypad, code);
        end
        tests++;
        if (key_down !== 1'b1) begin
          fails++;
          $display("FAIL %s down: key_down=%b want 1", name, key_down);
        end
      end
      if (n == 21) begin
        tests++;
        if (col_n !== col_pat(c)) begin
          fails++;
          $display("FAIL %s frozen_col: col_n=%b want %b", name, col_n, col_pat(c));
        end
      end
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL %s pulse_count: got %0d want 1", name, pulses);
    end
    tests++;
    if (pulse_at != 20) begin
      fails++;
      $display("FAIL %s latency: strobe at cycle %0d want 20", name, pulse_at);
    end
  endtask

  // Release: rows_s rises 2 edges later; release accepted 16 cycles after that.
  task automatic release_keys(input string name, input logic [15:0] mask, input int next_c);
    int rel_at = -1;
    int pulses = 0;
    keys = keys & ~mask;
    for (int j = 1; j <= 24; j++) begin
      @(negedge sys_clk);
      if (key_valid === 1'b1) pulses++;
      if (key_down !== 1'b1 && rel_at < 0) begin
        rel_at = j;
        tests++;
        if (keypad !== 4'b0000) begin
          fails++;
          $display("FAIL %s rel_code: keypad=%b want 0000", name, keypad);
        end
        tests++;
        if (col_n !== col_pat(next_c)) begin
          fails++;
          $display("FAIL %s rel_col: col_n=%b want %b", name, col_n, col_pat(next_c));
        end
      end
    end
    tests++;
    if (rel_at != 18) begin
      fails++;
      $display("FAIL %s rel_latency: key_down fell at cycle %0d want 18", name, rel_at);
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL %s rel_strobe: %0d key_valid pulses want 0", name, pulses);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if (col_n !== 4'b1110) begin
      fails++;
      $display("FAIL %s col_n: got %b want 1110", name, col_n);
    end
    tests++;
    if (keypad !== 4'b0000) begin
      fails++;
      $display("FAIL %s keypad: got %b want 0000", name, keypad);
    end
    tests++;
    if (key_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s key_valid: got %b want 0", name, key_valid);
    end
    tests++;
    if (key_down !== 1'b0) begin
      fails++;
      $display("FAIL %s key_down: got %b want 0", name, key_down);
    end
  endtask

  task automatic test_reset();
    force_low = 1'b1;
    reset     = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    reset     = 1'b0;
    force_low = 1'b0;
    for (int n = 0; n <= 16; n++) begin
      tests++;
      if (col_n !== col_pat((n / 4) % 4)) begin
        fails++;
        $display("FAIL rotate@%0d: col_n=%b want %b", n, col_n, col_pat((n / 4) % 4));
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic test_arm_key();
    press_keys("arm", key_bit(0, 3), 3, 4'b0011);
    release_keys("arm", key_bit(0, 3), 0);
  endtask

  task automatic test_disarm_key();
    press_keys("disarm", key_bit(3, 0), 0, 4'b1100);
    release_keys("disarm", key_bit(3, 0), 1);
    press_keys("row2col0", key_bit(2, 0), 0, 4'b1000);
    release_keys("row2col0", key_bit(2, 0), 1);
  endtask

  task automatic test_press_bounce();
    int pulses = 0;
    int downs  = 0;
    wait_col(1);
    keys = keys | key_bit(1, 1);
    for (int n = 1; n <= 13; n++) begin
      @(negedge sys_clk);
      if (n == 6) keys = keys & ~key_bit(1, 1);
      if (key_valid === 1'b1) pulses++;
      if (key_down !== 1'b0) downs++;
      if (n == 8 || n == 9 || n == 12 || n == 13) begin
        tests++;
        if (col_n !== col_pat((n < 9) ? 1 : (n < 13) ? 2 : 3)) begin
          fails++;
          $display("FAIL bounce_p col@%0d: col_n=%b want %b", n, col_n,
                   col_pat((n < 9) ? 1 : (n < 13) ? 2 : 3));
        end
      end
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL bounce_p strobe: %0d pulses want 0", pulses);
    end
    tests++;
    if (downs != 0) begin
      fails++;
      $display("FAIL bounce_p down: key_down high %0d cycles want 0", downs);
    end
  endtask

  task automatic test_release_bounce();
    int pulses   = 0;
    int bad_down = 0;
    int bad_code = 0;
    press_keys("bounce_r", key_bit(0, 1), 1, 4'b0001);
    keys = keys & ~key_bit(0, 1);
    for (int n = 1; n <= 30; n++) begin
      @(negedge sys_clk);
      if (n == 5) keys = keys | key_bit(0, 1);
      if (key_valid === 1'b1) pulses++;
      if (key_down !== 1'b1) bad_down++;
      if (keypad !== 4'b0001) bad_code++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL bounce_r strobe: %0d pulses want 0", pulses);
    end
    tests++;
    if (bad_down != 0) begin
      fails++;
      $display("FAIL bounce_r down: key_down low %0d cycles want 0", bad_down);
    end
    tests++;
    if (bad_code != 0) begin
      fails++;
      $display("FAIL bounce_r code: keypad changed in %0d cycles want 0", bad_code);
    end
    release_keys("bounce_r", key_bit(0, 1), 2);
  endtask

  task automatic test_multi_key();
    int pulses   = 0;
    int bad_code = 0;
    press_keys("multi", key_bit(1, 2) | key_bit(2, 2), 2, 4'b0110);
    keys = keys | key_bit(3, 0) | key_bit(3, 2);
    for (int n = 1; n <= 20; n++) begin
      @(negedge sys_clk);
      if (key_valid === 1'b1) pulses++;
      if (keypad !== 4'b0110 || key_down !== 1'b1) bad_code++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL multi strobe: %0d extra pulses want 0", pulses);
    end
    tests++;
    if (bad_code != 0) begin
      fails++;
      $display("FAIL multi hold: outputs changed in %0d cycles want 0", bad_code);
    end
    release_keys("multi", 16'hFFFF, 3);
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int downs  = 0;
    // Debounce count reaches 8 at the 12th edge after column 0 becomes active.
    wait_col(0);
    keys = keys | key_bit(0, 0);
    repeat (12) @(negedge sys_clk);
    reset = 1'b1;
    keys  = '0;
    @(negedge sys_clk);
    check_reset_outputs("rst_debounce");
    reset = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge sys_clk);
      if (key_valid === 1'b1) pulses++;
      if (key_down !== 1'b0) downs++;
    end
    tests++;
    if (pulses != 0 || downs != 0) begin
      fails++;
      $display("FAIL rst_debounce after: %0d pulses %0d down cycles want 0 0", pulses, downs);
    end
    press_keys("rst_pressed", key_bit(2, 1), 1, 4'b1001);
    repeat (5) @(negedge sys_clk);
    reset = 1'b1;
    keys  = '0;
    @(negedge sys_clk);
    check_reset_outputs("rst_pressed");
    reset = 1'b0;
  endtask

  task automatic test_autorepeat();
    int pulses = 0;
    int at[3];
    press_keys("repeat", key_bit(1, 3), 3, 4'b0111);
    // Initial strobe was at cycle 20; observe through cycle 120.
    for (int n = 22; n <= 120; n++) begin
      @(negedge sys_clk);
      if (key_valid === 1'b1) begin
        if (pulses < 3) at[pulses] = n;
        pulses++;
      end
    end
    tests++;
    if (pulses != EXP_REPEATS) begin
      fails++;
      $display("FAIL repeat count: got %0d want %0d", pulses, EXP_REPEATS);
    end
    for (int i = 0; i < pulses && i < 3; i++) begin
      tests++;
      if (at[i] != 52 + 32 * i) begin
        fails++;
        $display("FAIL repeat%0d time: cycle %0d want %0d", i, at[i], 52 + 32 * i);
      end
    end
    release_keys("repeat", key_bit(1, 3), 0);
  endtask

  initial begin
    test_reset();
    test_arm_key();
    test_disarm_key();
    test_press_bounce();
    test_release_bounce();
    test_multi_key();
    test_reset_mid();
    test_autorepeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
